// File: rtl/interconexion_nios_cpu_debug_mem_ctrl_pkg.sv
// Shared types and constants for the Nios debug-memory controller.
package interconexion_nios_cpu_debug_mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned CMD_ADDR_W   = 16;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned BE_W         = 4;
    localparam int unsigned JDO_W        = 38;

    // jdo field positions
    localparam int unsigned JDO_ADDR_MSB = 17;
    localparam int unsigned JDO_ADDR_LSB = 10;
    localparam int unsigned JDO_RD_BIT   = 34;
    localparam int unsigned JDO_DATA_MSB = 34;
    localparam int unsigned JDO_DATA_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_ACC,
        ST_J_CAP,
        ST_C_ACC,
        ST_C_CAP,
        ST_C_DONE
    } state_e;

    // One-deep JTAG command latch; inc marks a read that advances MonAReg
    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic                  inc;
        logic [CMD_ADDR_W-1:0] addr;
    } cmd_t;

endpackage

// File: rtl/interconexion_nios_cpu_debug_mem_ram.sv
// Single-port byte-enabled debug RAM, 1-cycle read latency, read-before-write.
module interconexion_nios_cpu_debug_mem_ram
    import interconexion_nios_cpu_debug_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/interconexion_nios_cpu_debug_mem_ctrl.sv
// JTAG monitor / CPU Avalon arbiter for the private debug RAM; JTAG has priority.
module interconexion_nios_cpu_debug_mem_ctrl
    import interconexion_nios_cpu_debug_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    state_e            state, state_nxt;
    cmd_t              cmd;
    logic              pulse_q, cmd_load, cmd_drop, cmd_clr, valid_nxt, j_nxt;
    logic              addr_load, addr_inc;
    logic [ADDR_W-1:0] jdo_addr, cmd_addr;
    logic              ram_we;
    logic [BE_W-1:0]   ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              unused_bits;

    assign jdo_addr  = ADDR_W'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
    assign cmd_addr  = ADDR_W'(cmd.addr);

    // Pulses that need the latch; an address-only load bypasses it
    assign pulse_q   = (take_action_ocimem_a & jdo[JDO_RD_BIT])
                     | take_no_action_ocimem_a | take_action_ocimem_b;
    assign cmd_load  = pulse_q & ~cmd.valid;
    assign cmd_drop  = pulse_q & cmd.valid;
    assign addr_load = take_action_ocimem_a & ~(jdo[JDO_RD_BIT] & cmd.valid);
    assign addr_inc  = (state == ST_IDLE && cmd.valid && cmd.is_write)
                     || (state == ST_J_CAP && cmd.inc);

    assign avs_waitrequest = (avs_read | avs_write) & (state != ST_C_DONE);
    assign unused_bits     = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0], cmd.addr};

    // Next state and RAM port steering
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        cmd_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd.valid)                                state_nxt = ST_J_ACC;
                else if (!cmd_load && (avs_read || avs_write)) state_nxt = ST_C_ACC;
            end
            ST_J_ACC: begin
                ram_addr = cmd_addr;
                if (cmd.is_write) begin
                    ram_we    = 1'b1;
                    ram_be    = '1;
                    ram_wdata = MonDReg;
                    cmd_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_J_CAP;
                end
            end
            ST_J_CAP: begin
                cmd_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_C_ACC: begin
                ram_addr = avs_address;
                if (avs_write) begin
                    ram_we    = 1'b1;
                    ram_be    = avs_byteenable;
                    ram_wdata = avs_writedata;
                    state_nxt = ST_C_DONE;
                end else begin
                    state_nxt = ST_C_CAP;
                end
            end
            ST_C_CAP:  state_nxt = ST_C_DONE;
            ST_C_DONE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        valid_nxt = cmd_load | (cmd.valid & ~cmd_clr);
        j_nxt     = (state_nxt == ST_J_ACC) || (state_nxt == ST_J_CAP);
    end

    // State, command latch and monitor registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cmd          <= '0;
            MonDReg      <= '0;
            MonAReg      <= '0;
            avs_readdata <= '0;
            jtag_busy    <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            jtag_busy <= valid_nxt | j_nxt;
            if (cmd_drop) jtag_overrun <= 1'b1;

            if (cmd_load) begin
                cmd.valid    <= 1'b1;
                cmd.is_write <= take_action_ocimem_b;
                cmd.inc      <= take_no_action_ocimem_a;
                cmd.addr     <= CMD_ADDR_W'(take_action_ocimem_a ? jdo_addr : MonAReg);
            end else if (cmd_clr) begin
                cmd.valid <= 1'b0;
            end

            if (take_action_ocimem_b && !cmd.valid) MonDReg <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
            else if (state == ST_J_CAP)             MonDReg <= ram_rdata;

            // A fresh address load overrides a concurrent auto-increment
            if (addr_load)     MonAReg <= jdo_addr;
            else if (addr_inc) MonAReg <= cmd_addr + ADDR_W'(1);

            if (state == ST_C_CAP) avs_readdata <= ram_rdata;
        end
    end

    interconexion_nios_cpu_debug_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_interconexion_nios_cpu_debug_mem_ctrl.sv
// Directed self-checking bench for the Nios debug-memory controller.
module tb_interconexion_nios_cpu_debug_mem_ctrl;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy;
    logic        jtag_overrun;

    int vec_cnt = 0;
    int err_cnt = 0;

    interconexion_nios_cpu_debug_mem_ctrl #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_a(input logic rd, input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[34] = rd;
        j[17:10] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_wr(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // kind: 0 = ocimem_a, 1 = no_action_ocimem_a, 2 = ocimem_b
    task automatic pulse(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_b    = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic wait_ack(output int waits);
        waits = 0;
        #1;
        while (avs_waitrequest !== 1'b0 && waits < 20) begin
            tick();
            waits++;
        end
    endtask

    task automatic cpu_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, output logic [31:0] rd, output int waits);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = wr;
        avs_read       = ~wr;
        wait_ack(waits);
        rd = avs_readdata;
        tick();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          w;

        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;

        #12;
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_monareg", 32'(MonAReg), 32'h0);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_busy", 32'(jtag_busy), 32'h0);
        chk("rst_overrun", 32'(jtag_overrun), 32'h0);
        chk("rst_waitreq", 32'(avs_waitrequest), 32'h0);
        reset_n = 1'b1;
        tick();

        // Preload RAM[0x10] through the CPU port, then JTAG address-load read
        cpu_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, w);
        chk("pre_wr_waits", 32'(w), 32'd2);
        pulse(0, mk_a(1'b1, 8'h10));
        chk("lda_monareg", 32'(MonAReg), 32'h10);
        chk("lda_busy_n1", 32'(jtag_busy), 32'h1);
        tick();
        tick();
        chk("lda_mondreg_n2", MonDReg, 32'h0);
        chk("lda_busy_n2", 32'(jtag_busy), 32'h1);
        tick();
        chk("lda_mondreg_n3", MonDReg, 32'hDEADBEEF);
        chk("lda_monareg_n3", 32'(MonAReg), 32'h10);
        chk("lda_busy_n3", 32'(jtag_busy), 32'h0);

        // Streamed writes across the address wrap
        pulse(0, mk_a(1'b0, 8'hFE));
        chk("ld_fe", 32'(MonAReg), 32'hFE);
        chk("ld_fe_busy", 32'(jtag_busy), 32'h0);
        pulse(2, mk_wr(32'h11111111));
        chk("wr1_mondreg", MonDReg, 32'h11111111);
        chk("wr1_monareg_n", 32'(MonAReg), 32'hFE);
        tick();
        chk("wr1_monareg_n1", 32'(MonAReg), 32'hFF);
        tick();
        chk("wr1_busy_n2", 32'(jtag_busy), 32'h0);
        pulse(2, mk_wr(32'h22222222));
        tick();
        tick();
        chk("wr2_wrap", 32'(MonAReg), 32'h00);
        chk("wr2_mondreg", MonDReg, 32'h22222222);

        // Streamed reads back across the wrap
        pulse(0, mk_a(1'b0, 8'hFE));
        pulse(1, '0);
        tick();
        tick();
        tick();
        chk("rd1_mondreg", MonDReg, 32'h11111111);
        chk("rd1_monareg", 32'(MonAReg), 32'hFF);
        pulse(1, '0);
        tick();
        tick();
        tick();
        chk("rd2_mondreg", MonDReg, 32'h22222222);
        chk("rd2_monareg", 32'(MonAReg), 32'h00);

        // CPU byte-enabled write and read-back
        cpu_xfer(1'b1, 8'h03, 32'h0, 4'hF, rd, w);
        cpu_xfer(1'b1, 8'h03, 32'hAABBCCDD, 4'b0101, rd, w);
        chk("be_wr_waits", 32'(w), 32'd2);
        cpu_xfer(1'b0, 8'h03, 32'h0, 4'hF, rd, w);
        chk("be_rd_waits", 32'(w), 32'd3);
        chk("be_rd_data", rd, 32'h00BB00DD);

        // JTAG write and CPU read in the same cycle
        pulse(0, mk_a(1'b0, 8'h20));
        jdo = mk_wr(32'h5A5A5A5A);
        take_action_ocimem_b = 1'b1;
        avs_address = 8'h20;
        avs_read = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        wait_ack(w);
        rd = avs_readdata;
        chk("col_waits", 32'(w), 32'd5);
        chk("col_data", rd, 32'h5A5A5A5A);
        chk("col_monareg", 32'(MonAReg), 32'h21);
        tick();
        avs_read = 1'b0;

        // Two JTAG pulses during a CPU read: first served, second dropped
        avs_address = 8'h03;
        avs_read = 1'b1;
        tick();
        chk("ovr_wait_cacc", 32'(avs_waitrequest), 32'h1);
        jdo = mk_a(1'b1, 8'h10);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        tick();
        chk("ovr_wait_cdone", 32'(avs_waitrequest), 32'h0);
        chk("ovr_cpu_data", avs_readdata, 32'h00BB00DD);
        jdo = mk_a(1'b1, 8'h30);
        take_action_ocimem_a = 1'b1;
        avs_read = 1'b0;
        tick();
        take_action_ocimem_a = 1'b0;
        chk("ovr_flag", 32'(jtag_overrun), 32'h1);
        chk("ovr_monareg_kept", 32'(MonAReg), 32'h10);
        tick();
        tick();
        tick();
        chk("ovr_first_served", MonDReg, 32'hDEADBEEF);
        chk("ovr_busy_done", 32'(jtag_busy), 32'h0);
        chk("ovr_sticky", 32'(jtag_overrun), 32'h1);

        // Reset while in J_CAP
        pulse(1, '0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("mrst_mondreg", MonDReg, 32'h0);
        chk("mrst_monareg", 32'(MonAReg), 32'h0);
        chk("mrst_busy", 32'(jtag_busy), 32'h0);
        chk("mrst_overrun", 32'(jtag_overrun), 32'h0);
        chk("mrst_readdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        tick();
        cpu_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd, w);
        chk("mrst_ram_kept", rd, 32'hDEADBEEF);
        chk("mrst_rd_waits", 32'(w), 32'd3);
        pulse(0, mk_a(1'b1, 8'h03));
        tick();
        tick();
        tick();
        chk("mrst_jtag_rd", MonDReg, 32'h00BB00DD);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
